// File: rtl/free_list.sv
`default_nettype none
// ============================================================================
// Module      : free_list (with helper pri_enc)
// Description : Free-list allocator for tag/entry IDs. A registered free-entry
//               bit vector feeds a lowest-index priority encoder, so one ID is
//               handed out per cycle through a zero-cycle req/ack handshake.
//               IDs are returned through a release port. Illegal releases
//               (out of range or double free) are dropped and raise a sticky
//               error flag.
// Optional    : FREE_LIST_BYPASS_EN - when no ID is free, an in-range released
//               ID is offered straight to the allocator in the same cycle.
// Ports       : clk, reset_ (sync, active-low), flush,
//               alloc_req / alloc_ack / alloc_id   - allocation handshake
//               free_valid / free_id               - release port
//               free_cnt, empty, full, err         - registered status
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// pri_enc: reports the lowest-index active request bit.
// ACT = "High" treats a 1 as a request, "Low" treats a 0 as a request.
// ----------------------------------------------------------------------------
module pri_enc #(
    parameter int    WIDTH = 32,
    parameter int    OUT_W = $clog2(WIDTH),
    parameter string ACT   = "High"
) (
    input  logic [WIDTH-1:0] in,
    output logic [OUT_W-1:0] out,
    output logic             valid
);

    logic [WIDTH-1:0] w_req;

    assign w_req = (ACT == "Low") ? ~in : in;
    assign valid = |w_req;

    // Scan from the top down so the last hit (the lowest index) wins.
    always_comb begin
        out = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                out = OUT_W'(i);
            end
        end
    end

endmodule

module free_list #(
    parameter int ENTRY = 32,
    parameter int OUT   = $clog2(ENTRY)
) (
    input  logic           clk,
    input  logic           reset_,
    input  logic           flush,
    input  logic           alloc_req,
    output logic           alloc_ack,
    output logic [OUT-1:0] alloc_id,
    input  logic           free_valid,
    input  logic [OUT-1:0] free_id,
    output logic [OUT:0]   free_cnt,
    output logic           empty,
    output logic           full,
    output logic           err
);

    localparam logic [OUT:0] c_ENTRY = (OUT + 1)'(ENTRY);

    logic [ENTRY-1:0] r_free_mask;
    logic [OUT:0]     r_free_cnt;
    logic             r_err;

    logic [ENTRY-1:0] w_mask_nxt;
    logic [OUT:0]     w_cnt_nxt;
    logic [OUT-1:0]   w_enc_id;
    logic             w_enc_valid;
    logic             w_mask_empty;
    logic             w_id_in_range;
    logic             w_free_legal;
    logic             w_free_illegal;
    logic             w_bypass;
    logic             w_alloc_fire;

    pri_enc #(
        .WIDTH (ENTRY),
        .OUT_W (OUT),
        .ACT   ("High")
    ) u_pri_enc (
        .in    (r_free_mask),
        .out   (w_enc_id),
        .valid (w_enc_valid)
    );

    assign w_mask_empty  = (r_free_mask == '0);
    assign w_id_in_range = ({1'b0, free_id} < c_ENTRY);

    // A release is legal only for an in-range ID that is currently taken.
    assign w_free_legal   = free_valid && w_id_in_range && !r_free_mask[free_id];
    assign w_free_illegal = free_valid && !w_free_legal;

`ifdef FREE_LIST_BYPASS_EN
    // Only reachable when nothing is free, so it never competes with the encoder.
    assign w_bypass = w_mask_empty && free_valid && w_id_in_range && !flush;
`else
    assign w_bypass = 1'b0;
`endif

    assign alloc_ack    = w_enc_valid || w_bypass;
    assign alloc_id     = w_bypass ? free_id : w_enc_id;
    assign w_alloc_fire = alloc_req && alloc_ack;

    // Set-then-clear ordering: in the bypass case the freed ID is consumed
    // immediately and the mask stays zero. Otherwise the two IDs always
    // differ, because a legal free targets a taken bit and alloc a free one.
    always_comb begin
        w_mask_nxt = r_free_mask;
        if (w_free_legal) begin
            w_mask_nxt[free_id] = 1'b1;
        end
        if (w_alloc_fire) begin
            w_mask_nxt[alloc_id] = 1'b0;
        end

        w_cnt_nxt = r_free_cnt;
        if (w_free_legal && !w_alloc_fire) begin
            w_cnt_nxt = r_free_cnt + 1'b1;
        end else if (!w_free_legal && w_alloc_fire) begin
            w_cnt_nxt = r_free_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            r_free_mask <= '1;
            r_free_cnt  <= c_ENTRY;
            r_err       <= 1'b0;
        end else if (flush) begin
            // Same-cycle alloc/free are discarded; the error flag persists.
            r_free_mask <= '1;
            r_free_cnt  <= c_ENTRY;
        end else begin
            r_free_mask <= w_mask_nxt;
            r_free_cnt  <= w_cnt_nxt;
            if (w_free_illegal) begin
                r_err <= 1'b1;
            end
        end
    end

    assign free_cnt = r_free_cnt;
    assign empty    = w_mask_empty;
    assign full     = (r_free_cnt == c_ENTRY);
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_free_list.sv
`default_nettype none
// ============================================================================
// Module      : tb_free_list
// Description : Self-checking bench for free_list (ENTRY = 8). A set-of-IDs
//               reference model predicts handshake and status every cycle;
//               directed scenarios are followed by a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_free_list;

    localparam int ENTRY = 8;
    localparam int OUT   = 3;

    logic           clk = 1'b0;
    logic           reset_;
    logic           flush;
    logic           alloc_req;
    logic           alloc_ack;
    logic [OUT-1:0] alloc_id;
    logic           free_valid;
    logic [OUT-1:0] free_id;
    logic [OUT:0]   free_cnt;
    logic           empty;
    logic           full;
    logic           err;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: which IDs are free, plus the sticky error.
    bit m_free [ENTRY];
    bit m_err;

    free_list #(.ENTRY(ENTRY)) dut (
        .clk        (clk),
        .reset_     (reset_),
        .flush      (flush),
        .alloc_req  (alloc_req),
        .alloc_ack  (alloc_ack),
        .alloc_id   (alloc_id),
        .free_valid (free_valid),
        .free_id    (free_id),
        .free_cnt   (free_cnt),
        .empty      (empty),
        .full       (full),
        .err        (err)
    );

    always #5 clk = ~clk;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < ENTRY; i++) n += m_free[i];
        return n;
    endfunction

    function automatic int m_lowest();
        for (int i = 0; i < ENTRY; i++) if (m_free[i]) return i;
        return -1;
    endfunction

    function automatic logic [ENTRY-1:0] m_mask();
        logic [ENTRY-1:0] v;
        for (int i = 0; i < ENTRY; i++) v[i] = m_free[i];
        return v;
    endfunction

    task automatic m_reset_all(input bit clear_err);
        for (int i = 0; i < ENTRY; i++) m_free[i] = 1'b1;
        if (clear_err) m_err = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check everything against the model, clock it.
    task automatic step(input bit r, input bit f, input bit req, input bit fv, input int fid);
        int  low;
        int  exp_id;
        bit  exp_ack;
        bit  legal;
        reset_     = r;
        flush      = f;
        alloc_req  = req;
        free_valid = fv;
        free_id    = OUT'(fid);
        #1;
        low     = m_lowest();
        exp_ack = (low >= 0);
        exp_id  = low;
`ifdef FREE_LIST_BYPASS_EN
        if (!exp_ack && fv && fid < ENTRY && !f) begin
            exp_ack = 1'b1;
            exp_id  = fid;
        end
`endif
        chk("alloc_ack", {31'd0, alloc_ack}, {31'd0, exp_ack});
        if (exp_ack) chk("alloc_id", {29'd0, alloc_id}, exp_id);
        chk("free_cnt", {28'd0, free_cnt}, m_count());
        chk("empty", {31'd0, empty}, (m_count() == 0) ? 1 : 0);
        chk("full", {31'd0, full}, (m_count() == ENTRY) ? 1 : 0);
        chk("err", {31'd0, err}, {31'd0, m_err});
        chk("free_mask", {24'd0, dut.r_free_mask}, {24'd0, m_mask()});
        @(posedge clk);
        if (!r) begin
            m_reset_all(1'b1);
        end else if (f) begin
            m_reset_all(1'b0);
        end else begin
            legal = fv && (fid < ENTRY) && !m_free[fid];
            if (legal) m_free[fid] = 1'b1;
            if (req && exp_ack) m_free[exp_id] = 1'b0;
            if (fv && !legal) m_err = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        reset_     = 1'b1;
        flush      = 1'b0;
        alloc_req  = 1'b0;
        free_valid = 1'b0;
        free_id    = '0;
        #1;
    endtask

    initial begin
        int r_r, r_f, r_req, r_fv, r_id;

        // Bring-up reset with no checks while the DUT is still unknown.
        reset_ = 1'b0; flush = 1'b0; alloc_req = 1'b0; free_valid = 1'b0; free_id = '0;
        repeat (2) @(posedge clk);
        #1;
        m_reset_all(1'b1);

        // Reset state.
        idle();
        chk("rst_ack", {31'd0, alloc_ack}, 1);
        chk("rst_id", {29'd0, alloc_id}, 0);
        chk("rst_cnt", {28'd0, free_cnt}, 8);
        chk("rst_full", {31'd0, full}, 1);
        chk("rst_empty", {31'd0, empty}, 0);

        // Eight back-to-back allocations drain the list in ascending order.
        for (int i = 0; i < ENTRY; i++) step(1, 0, 1, 0, 0);
        idle();
        chk("drain_ack", {31'd0, alloc_ack}, 0);
        chk("drain_empty", {31'd0, empty}, 1);
        chk("drain_cnt", {28'd0, free_cnt}, 0);

        // Free 5 then 2, then allocate twice: 2 comes back before 5.
        step(1, 0, 0, 1, 5);
        step(1, 0, 0, 1, 2);
        idle();
        chk("refill_id", {29'd0, alloc_id}, 2);
        step(1, 0, 1, 0, 0);
        idle();
        chk("refill_id2", {29'd0, alloc_id}, 5);
        step(1, 0, 1, 0, 0);
        idle();
        chk("refill_cnt", {28'd0, free_cnt}, 0);

        // Concurrent alloc of 3 and free of 1 with 0..2 taken.
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0);
        step(1, 0, 1, 1, 1);
        idle();
        chk("conc_mask", {24'd0, dut.r_free_mask}, 32'hF2);
        chk("conc_cnt", {28'd0, free_cnt}, 5);
        chk("conc_id", {29'd0, alloc_id}, 1);

        // Double free of 6 sets err; flush keeps it; reset clears it.
        step(1, 0, 0, 1, 6);
        idle();
        chk("dbl_err", {31'd0, err}, 1);
        chk("dbl_cnt", {28'd0, free_cnt}, 5);
        step(1, 1, 0, 0, 0);
        idle();
        chk("flush_err", {31'd0, err}, 1);
        step(0, 0, 0, 0, 0);
        idle();
        chk("reset_err", {31'd0, err}, 0);

        // Flush with five IDs taken and a concurrent alloc.
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        idle();
        chk("flush_cnt", {28'd0, free_cnt}, 8);
        chk("flush_full", {31'd0, full}, 1);
        chk("flush_id", {29'd0, alloc_id}, 0);

        // Release of 4 with alloc_req while the list is empty.
        for (int i = 0; i < ENTRY; i++) step(1, 0, 1, 0, 0);
        reset_ = 1'b1; flush = 1'b0; alloc_req = 1'b1; free_valid = 1'b1; free_id = 3'd4;
        #1;
`ifdef FREE_LIST_BYPASS_EN
        chk("byp_ack", {31'd0, alloc_ack}, 1);
        chk("byp_id", {29'd0, alloc_id}, 4);
`else
        chk("byp_ack", {31'd0, alloc_ack}, 0);
`endif
        step(1, 0, 1, 1, 4);
        idle();
`ifdef FREE_LIST_BYPASS_EN
        chk("byp_cnt", {28'd0, free_cnt}, 0);
        chk("byp_empty", {31'd0, empty}, 1);
`else
        chk("byp_cnt", {28'd0, free_cnt}, 1);
        chk("byp_empty", {31'd0, empty}, 0);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            r_r   = ($urandom_range(0, 99) < 1) ? 0 : 1;
            r_f   = ($urandom_range(0, 99) < 3) ? 1 : 0;
            r_req = ($urandom_range(0, 99) < 60) ? 1 : 0;
            r_fv  = ($urandom_range(0, 99) < 50) ? 1 : 0;
            r_id  = $urandom_range(0, ENTRY - 1);
            step(r_r[0], r_f[0], r_req[0], r_fv[0], r_id);
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
